byte_serial_adder_ctrl: RTL and testbench

Sequencer that time-shares a single 8-bit adder slice to compute an (8·NBYTES)-bit sum byte-serially, least-significant byte first, with a registered carry chain. It sits between the switch-bank operand inputs and the light-bank result outputs of the adder test designs. It replaces a wide combinational adder with a small, routable datapath plus a start/busy/done handshake.

---
 rtl/mcpnr_adder_pkg.sv | 17 +
 rtl/adder_slice.sv | 13 +
 rtl/byte_serial_adder_ctrl.sv | 95 +++++++++
 tb/tb_byte_serial_adder_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcpnr_adder_pkg.sv
// Shared types and constants for the byte-serial adder sequencer.
package mcpnr_adder_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte-counter width: ceil(log2(nbytes)), never below one bit.
    function automatic int idx_width(input int nbytes);
        return (nbytes <= 2) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// One 8-bit adder with carry-in; the only arithmetic in the sequencer.
module adder_slice
    import mcpnr_adder_pkg::*;
(
    input  logic [BYTE_W-1:0] A,
    input  logic [BYTE_W-1:0] B,
    input  logic              CI,
    output logic [BYTE_W:0]   Y
);

    assign Y = {1'b0, A} + {1'b0, B} + {{BYTE_W{1'b0}}, CI};

endmodule

// File: rtl/byte_serial_adder_ctrl.sv
// Byte-serial wide adder: one shared slice, LSB byte first, registered carry,
// start/busy/done handshake.
module byte_serial_adder_ctrl
    import mcpnr_adder_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BYTE_W*NBYTES-1:0]   a,
    input  logic [BYTE_W*NBYTES-1:0]   b,
    output logic                       busy,
    output logic                       done,
    output logic [BYTE_W*NBYTES:0]     y
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t             state, state_next;
    logic               accept;
    logic               last;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [W-1:0]       a_r, b_r;
    logic [W-1:0]       partial_r, partial_upd;
    logic [BYTE_W:0]    slice_y;

    adder_slice u_slice (
        .A  (a_r[BYTE_W*idx +: BYTE_W]),
        .B  (b_r[BYTE_W*idx +: BYTE_W]),
        .CI (carry),
        .Y  (slice_y)
    );

    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            RUN:     if (idx == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: begin
                // The unused encoding behaves as IDLE.
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
        endcase
    end

    assign last = (state == RUN) && (idx == LAST_IDX);
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        partial_upd                            = partial_r;
        partial_upd[BYTE_W*idx +: BYTE_W]      = slice_y[BYTE_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: the datapath registers are all reset, so y and the operand
    // latches read zero after reset instead of stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            partial_r <= '0;
            y         <= '0;
        end else if (accept) begin
            a_r   <= a;
            b_r   <= b;
            idx   <= '0;
            carry <= 1'b0;
        end else if (state == RUN) begin
            carry     <= slice_y[BYTE_W];
            partial_r <= partial_upd;
            if (last) y   <= {slice_y[BYTE_W], partial_upd};
            else      idx <= idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_byte_serial_adder_ctrl.sv
// Self-checking bench: timeline reference model per DUT plus directed scenarios.
module tb_byte_serial_adder_ctrl;

    localparam int N  = 4;
    localparam int N1 = 1;

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic        start  = 1'b0;
    logic [31:0] a      = '0;
    logic [31:0] b      = '0;
    logic        busy, done;
    logic [32:0] y;

    logic        start1 = 1'b0;
    logic [7:0]  a1     = '0;
    logic [7:0]  b1     = '0;
    logic        busy1, done1;
    logic [8:0]  y1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    byte_serial_adder_ctrl #(.NBYTES(N)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .y(y)
    );

    byte_serial_adder_ctrl #(.NBYTES(N1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .y(y1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase counts edges since acceptance (0 = idle).
    // busy during phases 1..N, done at N+1, y takes the full sum at N+1.
    int          m_phase = 0;
    logic [32:0] m_pend  = '0;
    logic [32:0] m_y     = '0;
    int          m1_phase = 0;
    logic [8:0]  m1_pend  = '0;
    logic [8:0]  m1_y     = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_y     <= '0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_pend  <= {1'b0, a} + {1'b0, b};
                m_phase <= 1;
            end
        end else if (m_phase == N + 1) begin
            m_phase <= 0;
        end else begin
            m_phase <= m_phase + 1;
            if (m_phase == N) m_y <= m_pend;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1_phase <= 0;
            m1_y     <= '0;
        end else if (m1_phase == 0) begin
            if (start1) begin
                m1_pend  <= {1'b0, a1} + {1'b0, b1};
                m1_phase <= 1;
            end
        end else if (m1_phase == N1 + 1) begin
            m1_phase <= 0;
        end else begin
            m1_phase <= m1_phase + 1;
            if (m1_phase == N1) m1_y <= m1_pend;
        end
    end

    always @(negedge clk) begin
        check("busy",  busy,  (m_phase >= 1) && (m_phase <= N));
        check("done",  done,  m_phase == N + 1);
        check("y",     y,     m_y);
        check("busy1", busy1, (m1_phase >= 1) && (m1_phase <= N1));
        check("done1", done1, m1_phase == N1 + 1);
        check("y1",    y1,    m1_y);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int bound, output int ticks);
        ticks = 0;
        while (!done && ticks < bound) begin
            tick();
            ticks++;
        end
        check("done_timeout", done, 1'b1);
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) cnt++;
        end
    endtask

    task automatic pulse_start(input logic [31:0] av, input logic [31:0] bv);
        a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom; b = $urandom;
    endtask

    initial begin
        int t, cnt, gap;
        logic [32:0] exp_sum;
        logic [31:0] ra, rb;

        #2 rst = 1'b1;
        tick(); tick();
        check("rst_y", y, 33'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;
        tick();

        // Basic sum: busy right after acceptance, done N edges later.
        pulse_start(32'h12345678, 32'h11111111);
        check("t1_busy", busy, 1'b1);
        wait_done(10, t);
        check("t1_latency", t, N);
        check("t1_y", y, 33'h023456789);
        tick();
        check("t1_pulse_len", done, 1'b0);

        // Carry ripples through every byte.
        pulse_start(32'hFFFFFFFF, 32'h00000001);
        wait_done(10, t);
        check("t2_y", y, 33'h100000000);
        tick();

        // A second start during RUN is ignored.
        pulse_start(32'h12345678, 32'h11111111);
        tick();
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(10, t);
        check("t3_latency", t, N - 2);
        check("t3_y", y, 33'h023456789);
        count_done(10, cnt);
        check("t3_single_done", cnt, 0);
        check("t3_y_hold", y, 33'h023456789);

        // start held high: one result every N+2 cycles.
        a = 32'h1; b = 32'h2; start = 1'b1;
        tick();
        wait_done(10, t);
        check("t4_latency", t, N);
        check("t4_y0", y, 33'h3);
        for (int k = 1; k < 3; k++) begin
            tick();
            wait_done(12, t);
            gap = t + 1;
            check("t4_period", gap, N + 2);
            check("t4_y", y, 33'h3);
        end
        start = 1'b0;
        tick(); tick();

        // Reset mid-RUN abandons the operation immediately.
        pulse_start(32'hDEADBEEF, 32'h01020304);
        tick();
        rst = 1'b1;
        #1;
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        check("t5_y", y, 33'h0);
        tick();
        rst = 1'b0;
        count_done(10, cnt);
        check("t5_no_done", cnt, 0);
        ra = $urandom; rb = $urandom;
        exp_sum = {1'b0, ra} + {1'b0, rb};
        pulse_start(ra, rb);
        wait_done(10, t);
        check("t5_after_y", y, exp_sum);
        tick();

        // Single-byte instance.
        a1 = 8'hFF; b1 = 8'hFF; start1 = 1'b1;
        tick();
        start1 = 1'b0; a1 = 8'h00; b1 = 8'h00;
        check("t6_busy", busy1, 1'b1);
        check("t6_done_early", done1, 1'b0);
        tick();
        check("t6_busy_end", busy1, 1'b0);
        check("t6_done", done1, 1'b1);
        check("t6_y", y1, 9'h1FE);
        tick();
        check("t6_done_end", done1, 1'b0);

        // Random traffic with occasional stray starts and resets.
        for (int i = 0; i < 300; i++) begin
            a  = $urandom; b  = $urandom;
            a1 = 8'($urandom); b1 = 8'($urandom);
            start  = ($urandom_range(0, 2) != 0);
            start1 = ($urandom_range(0, 1) != 0);
            rst    = ($urandom_range(0, 59) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0; start1 = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
